// File: rtl/exp_block_align_sched_if.sv
// Handshake bundle between the activation fetch stage, the alignment scheduler
// and the mantissa shifters: a group input channel and a replay output channel.
interface exp_block_align_sched_if #(
   parameter int EXP_W = 5
);
   logic               in_valid;
   logic               in_ready;
   logic [4*EXP_W-1:0] in_exp;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic [4*EXP_W-1:0] out_shift;
   logic [EXP_W-1:0]   out_max_exp;
   logic [3:0]         out_sel;
   logic               out_last;

   modport master (
      output in_valid, in_exp, in_last, out_ready,
      input  in_ready, out_valid, out_shift, out_max_exp, out_sel, out_last
   );

   modport slave (
      input  in_valid, in_exp, in_last, out_ready,
      output in_ready, out_valid, out_shift, out_max_exp, out_sel, out_last
   );
endinterface

// File: rtl/exp_block_align_sched.sv
// Block-floating-point alignment scheduler: buffers groups of four exponents,
// tracks the block maximum, then replays each group with per-lane shift amounts.
module exp_block_align_sched #(
   parameter int DEPTH = 8,
   parameter int EXP_W = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   exp_block_align_sched_if.slave  bus,
   output logic                    busy
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, ACCUM, REPLAY} state_t;

   state_t             state;
   state_t             state_next;
   logic [4*EXP_W-1:0] buffer [DEPTH];
   logic [CW-1:0]      wr_cnt;
   logic [CW-1:0]      rd_idx;
   logic [EXP_W-1:0]   run_max;

   logic               accept;
   logic               emit;
   logic               close_block;
   logic               replay_last;
   logic [CW-1:0]      wr_cnt_next;
   logic [EXP_W-1:0]   lane [4];
   logic [EXP_W-1:0]   rd_lane [4];
   logic [EXP_W-1:0]   max01;
   logic [EXP_W-1:0]   max23;
   logic [EXP_W-1:0]   grp_max;
   logic [EXP_W-1:0]   new_max;
   logic [4*EXP_W-1:0] rd_data;

   assign bus.in_ready = rst_n && (state == IDLE || state == ACCUM);
   assign accept       = bus.in_valid && bus.in_ready;
   assign emit         = bus.out_valid && bus.out_ready;
   assign busy         = (state != IDLE);
   assign rd_data      = buffer[rd_idx[AW-1:0]];
   assign replay_last  = (rd_idx == wr_cnt - CW'(1));

   // Group max as a two-level tournament; ">=" lets the higher lane win ties.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lane[i]    = bus.in_exp[i*EXP_W +: EXP_W];
         rd_lane[i] = rd_data[i*EXP_W +: EXP_W];
      end
      max01       = (lane[1] >= lane[0]) ? lane[1] : lane[0];
      max23       = (lane[3] >= lane[2]) ? lane[3] : lane[2];
      grp_max     = (max23 >= max01) ? max23 : max01;
      new_max     = (state == IDLE || grp_max > run_max) ? grp_max : run_max;
      wr_cnt_next = (state == IDLE) ? CW'(1) : wr_cnt + CW'(1);
      close_block = bus.in_last || (wr_cnt_next == CW'(DEPTH));
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, ACCUM: if (accept) state_next = close_block ? REPLAY : ACCUM;
         REPLAY:      if (emit && replay_last) state_next = IDLE;
         default:     state_next = IDLE;
      endcase
   end

   // Outputs stay zero outside REPLAY; the highest matching lane wins out_sel.
   always_comb begin
      bus.out_valid   = 1'b0;
      bus.out_shift   = '0;
      bus.out_max_exp = '0;
      bus.out_sel     = '0;
      bus.out_last    = 1'b0;
      if (state == REPLAY) begin
         bus.out_valid   = 1'b1;
         bus.out_max_exp = run_max;
         bus.out_last    = replay_last;
         for (int i = 0; i < 4; i++) begin
            bus.out_shift[i*EXP_W +: EXP_W] = run_max - rd_lane[i];
            if (rd_lane[i] == run_max) begin
               bus.out_sel    = '0;
               bus.out_sel[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_cnt  <= '0;
         rd_idx  <= '0;
         run_max <= '0;
      end else begin
         if (accept) begin
            wr_cnt  <= wr_cnt_next;
            run_max <= new_max;
         end
         if (emit) begin
            if (replay_last) begin
               wr_cnt  <= '0;
               rd_idx  <= '0;
               run_max <= '0;
            end else begin
               rd_idx <= rd_idx + CW'(1);
            end
         end
      end
   end

   // Group storage carries no reset; entries are only read after being written.
   always_ff @(posedge clk) begin
      if (accept) buffer[wr_cnt[AW-1:0]] <= bus.in_exp;
   end
endmodule

// File: tb/tb_exp_block_align_sched.sv
// Scoreboard bench for exp_block_align_sched: directed blocks push hand-computed
// replay results, and a negedge monitor compares whatever the scheduler presents.
module tb_exp_block_align_sched;
   localparam int DEPTH = 8;
   localparam int EXP_W = 5;

   typedef struct packed {
      logic [4*EXP_W-1:0] shift;
      logic [EXP_W-1:0]   max_exp;
      logic [3:0]         sel;
      logic               last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;

   exp_block_align_sched_if #(.EXP_W(EXP_W)) bus ();

   exp_block_align_sched #(.DEPTH(DEPTH), .EXP_W(EXP_W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   exp_t sb_q[$];
   exp_t mon_exp;
   int   check_count = 0;
   int   fail_count = 0;
   int   emit_count = 0;
   int   cycle = 0;
   int   last_emit_edge = -1;
   int   last_accept_edge = -1;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check_output(input string name, input int actual, input int expected);
      check_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   task automatic push_exp(input int s0, input int s1, input int s2, input int s3,
                           input int mx, input logic [3:0] sel, input logic last);
      exp_t e;
      e.shift   = {EXP_W'(s3), EXP_W'(s2), EXP_W'(s1), EXP_W'(s0)};
      e.max_exp = EXP_W'(mx);
      e.sel     = sel;
      e.last    = last;
      sb_q.push_back(e);
   endtask

   // Monitor: stalled outputs are re-checked against the same expected entry.
   always @(negedge clk) begin
      if (bus.out_valid) begin
         if (sb_q.size() == 0) begin
            check_count++;
            fail_count++;
            $display("[TB] FAIL unexpected_output: got shift 0x%0h max %0d, required no output",
                     bus.out_shift, bus.out_max_exp);
         end else begin
            mon_exp = sb_q[0];
            check_output("out_shift", int'(bus.out_shift), int'(mon_exp.shift));
            check_output("out_max_exp", int'(bus.out_max_exp), int'(mon_exp.max_exp));
            check_output("out_sel", int'(bus.out_sel), int'(mon_exp.sel));
            check_output("out_last", int'(bus.out_last), int'(mon_exp.last));
            if (bus.out_ready) begin
               void'(sb_q.pop_front());
               emit_count++;
               if (bus.out_last) last_emit_edge = cycle + 1;
            end
         end
      end else begin
         check_output("quiet_outputs",
                      int'({bus.out_shift, bus.out_max_exp, bus.out_sel, bus.out_last}), 0);
      end
   end

   task automatic apply_stimulus(input int e0, input int e1, input int e2, input int e3,
                                 input logic last);
      int waited;
      waited = 0;
      bus.in_valid = 1'b1;
      bus.in_exp   = {EXP_W'(e3), EXP_W'(e2), EXP_W'(e1), EXP_W'(e0)};
      bus.in_last  = last;
      @(negedge clk);
      while (!bus.in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         check_count++;
         fail_count++;
         $display("[TB] FAIL accept_timeout: got in_ready 0 for %0d cycles, required 1", waited);
      end else begin
         last_accept_edge = cycle + 1;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_exp   = '0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check_output(name, sb_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int bp_pattern [6];
      int first_last_edge;
      bp_pattern = '{0, 1, 0, 0, 1, 1};

      bus.in_valid  = 1'b0;
      bus.in_exp    = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check_output("reset_in_ready", int'(bus.in_ready), 0);
      check_output("reset_out_valid", int'(bus.out_valid), 0);
      check_output("reset_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_output("idle_in_ready", int'(bus.in_ready), 1);
      check_output("idle_busy", int'(busy), 0);
      @(posedge clk);
      #1;

      // Basic block
      bus.out_ready = 1'b1;
      base = emit_count;
      push_exp(30, 29, 28, 27, 31, 4'b0000, 1'b0);
      push_exp(21, 26, 26, 26, 31, 4'b0000, 1'b0);
      push_exp(31, 31, 31, 0, 31, 4'b1000, 1'b1);
      apply_stimulus(1, 2, 3, 4, 1'b0);
      apply_stimulus(10, 5, 5, 5, 1'b0);
      apply_stimulus(0, 0, 0, 31, 1'b1);
      wait_drain("basic_drain");
      check_output("basic_emits", emit_count - base, 3);

      // All-tie group
      base = emit_count;
      push_exp(0, 0, 0, 0, 7, 4'b1000, 1'b1);
      apply_stimulus(7, 7, 7, 7, 1'b1);
      wait_drain("tie_drain");
      check_output("tie_emits", emit_count - base, 1);

      // Forced close at DEPTH groups
      bus.out_ready = 1'b0;
      base = emit_count;
      for (int k = 0; k < 8; k++)
         push_exp(7 - k, 7, 7, 7, 7, (k == 7) ? 4'b0001 : 4'b0000, k == 7);
      for (int k = 0; k < 8; k++) apply_stimulus(k, 0, 0, 0, 1'b0);
      @(negedge clk);
      check_output("forced_in_ready", int'(bus.in_ready), 0);
      check_output("forced_busy", int'(busy), 1);
      check_output("forced_out_valid", int'(bus.out_valid), 1);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      wait_drain("forced_drain");
      check_output("forced_emits", emit_count - base, 8);

      // Backpressure on the basic block
      bus.out_ready = 1'b0;
      base = emit_count;
      push_exp(30, 29, 28, 27, 31, 4'b0000, 1'b0);
      push_exp(21, 26, 26, 26, 31, 4'b0000, 1'b0);
      push_exp(31, 31, 31, 0, 31, 4'b1000, 1'b1);
      apply_stimulus(1, 2, 3, 4, 1'b0);
      apply_stimulus(10, 5, 5, 5, 1'b0);
      apply_stimulus(0, 0, 0, 31, 1'b1);
      for (int p = 0; p < 6; p++) begin
         bus.out_ready = bp_pattern[p][0];
         @(negedge clk);
         check_output("bp_in_ready_low", int'(bus.in_ready), 0);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check_output("bp_in_ready_back", int'(bus.in_ready), 1);
      check_output("bp_emits", emit_count - base, 3);
      check_output("bp_queue_empty", sb_q.size(), 0);
      @(posedge clk);
      #1;

      // Reset in the middle of ACCUM discards the partial block
      base = emit_count;
      apply_stimulus(9, 9, 9, 9, 1'b0);
      apply_stimulus(1, 1, 1, 1, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_exp(0, 2, 2, 2, 3, 4'b0001, 1'b1);
      apply_stimulus(3, 1, 1, 1, 1'b1);
      wait_drain("rst_drain");
      repeat (3) @(posedge clk);
      #1;
      check_output("rst_emits", emit_count - base, 1);

      // Back-to-back blocks with in_valid held high
      base = emit_count;
      push_exp(7, 7, 7, 0, 9, 4'b1000, 1'b1);
      push_exp(0, 0, 0, 0, 4, 4'b1000, 1'b1);
      apply_stimulus(2, 2, 2, 9, 1'b1);
      apply_stimulus(4, 4, 4, 4, 1'b1);
      first_last_edge = last_emit_edge;
      check_output("b2b_accept_edge", last_accept_edge, first_last_edge + 1);
      wait_drain("b2b_drain");
      check_output("b2b_emits", emit_count - base, 2);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end
endmodule
